// File: rtl/noc_pkg.sv
// Shared port indices plus the XY route and round-robin pick helpers for the mesh router.
// Pure combinational helpers: no latency, no flow control of their own.
package noc_pkg;

  localparam int NPORTS = 5;

  localparam logic [2:0] PORT_W = 3'd0;
  localparam logic [2:0] PORT_E = 3'd1;
  localparam logic [2:0] PORT_S = 3'd2;
  localparam logic [2:0] PORT_N = 3'd3;
  localparam logic [2:0] PORT_L = 3'd4;

  // X is resolved completely before Y is considered.
  function automatic logic [2:0] route_xy(input logic [15:0] dx, input logic [15:0] dy,
                                          input logic [15:0] mx, input logic [15:0] my);
    logic [2:0] port;
    if (dx > mx)      port = PORT_E;
    else if (dx < mx) port = PORT_W;
    else if (dy > my) port = PORT_N;
    else if (dy < my) port = PORT_S;
    else              port = PORT_L;
    return port;
  endfunction

  // Scans last+1 .. last+5 (mod 5); the lowest offset with a request wins.
  function automatic logic [2:0] rr_pick(input logic [NPORTS-1:0] req, input logic [2:0] last);
    logic [2:0] pick;
    logic [2:0] idx;
    pick = last;
    for (int i = NPORTS; i >= 1; i--) begin
      idx = 3'((int'(last) + i) % NPORTS);
      if (req[idx]) pick = idx;
    end
    return pick;
  endfunction

endpackage

// File: rtl/noc_in_fifo.sv
// Per-port input FIFO, DEPTH entries; the head is readable in the cycle after the push edge.
// Pushes while full and pops while empty are ignored, so the producer must honour full.
module noc_in_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/noc_router_xy.sv
// 5-port XY mesh router: input FIFOs, per-output round-robin, registered outputs; 1 cycle FIFO residency minimum.
// in_ready tracks FIFO space only; a stalled output holds its data and stops granting.
module noc_router_xy
  import noc_pkg::*;
#(
  parameter int WIDTH   = 33,
  parameter int COORD_W = 2,
  parameter int DEPTH   = 4,
  parameter int MY_X    = 0,
  parameter int MY_Y    = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NPORTS*WIDTH-1:0] in_data,
  input  logic [NPORTS-1:0]       in_valid,
  output logic [NPORTS-1:0]       in_ready,
  output logic [NPORTS*WIDTH-1:0] out_data,
  output logic [NPORTS-1:0]       out_valid,
  input  logic [NPORTS-1:0]       out_ready,
  output logic [NPORTS-1:0]       err_uturn
);

  logic [WIDTH-1:0]  head       [NPORTS];
  logic [WIDTH-1:0]  out_reg    [NPORTS];
  logic [2:0]        route      [NPORTS];
  logic [NPORTS-1:0] req        [NPORTS];
  logic [2:0]        grant_idx  [NPORTS];
  logic [2:0]        last_grant [NPORTS];
  logic [NPORTS-1:0] full;
  logic [NPORTS-1:0] empty;
  logic [NPORTS-1:0] push;
  logic [NPORTS-1:0] pop;
  logic [NPORTS-1:0] uturn;
  logic [NPORTS-1:0] grant_vld;

  assign in_ready  = ~full & {NPORTS{!reset}};
  assign err_uturn = uturn & {NPORTS{!reset}};
  assign push      = in_valid & in_ready;

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    noc_in_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push[p]),
      .push_data (in_data[p*WIDTH +: WIDTH]),
      .pop       (pop[p]),
      .full      (full[p]),
      .empty     (empty[p]),
      .head      (head[p])
    );
    assign out_data[p*WIDTH +: WIDTH] = out_reg[p];
  end

  always_comb begin
    uturn     = '0;
    pop       = '0;
    grant_vld = '0;
    for (int o = 0; o < NPORTS; o++) begin
      req[o]       = '0;
      grant_idx[o] = '0;
    end
    for (int p = 0; p < NPORTS; p++) begin
      route[p] = route_xy(16'(head[p][WIDTH-2 -: COORD_W]),
                          16'(head[p][WIDTH-2-COORD_W -: COORD_W]),
                          16'(MY_X), 16'(MY_Y));
      // Only mesh ports can bounce a packet straight back; local traffic never U-turns.
      uturn[p] = !empty[p] && (p < NPORTS-1) && (route[p] == 3'(p));
      if (!empty[p] && !uturn[p]) req[route[p]][p] = 1'b1;
    end
    for (int o = 0; o < NPORTS; o++) begin
      grant_idx[o] = rr_pick(req[o], last_grant[o]);
      grant_vld[o] = (|req[o]) && (!out_valid[o] || out_ready[o]);
      if (grant_vld[o]) pop[grant_idx[o]] = 1'b1;
    end
    pop = pop | uturn;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int o = 0; o < NPORTS; o++) begin
        out_valid[o]  <= 1'b0;
        out_reg[o]    <= '0;
        last_grant[o] <= PORT_L;
      end
    end else begin
      for (int o = 0; o < NPORTS; o++) begin
        if (grant_vld[o]) begin
          out_reg[o]    <= head[grant_idx[o]];
          out_valid[o]  <= 1'b1;
          last_grant[o] <= grant_idx[o];
        end else if (out_ready[o]) begin
          out_valid[o]  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/noc_router_xy.md
# noc_router_xy

Clocked, parametrised 5-port mesh NoC router. Each input port has a DEPTH-entry FIFO; a per-output round-robin arbiter and a single-entry registered output stage forward packets. Routing is dimension-order XY, X first, on a COORD_W-bit coordinate. One instance sits at every mesh node; neighbours connect West↔East and South↔North, and the local PE connects on port 4.

## Interface
- WIDTH, 33: packet width in bits. Bit WIDTH-1 is reserved and passes through unchanged.
- COORD_W, 2: bits per coordinate. dest X = pkt[WIDTH-2 -: COORD_W]; dest Y = pkt[WIDTH-2-COORD_W -: COORD_W].
- DEPTH, 4: input FIFO entries per port. Power of 2, ≥2.
- MY_X, 0: this node's X coordinate.
- MY_Y, 0: this node's Y coordinate.
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_data  in  5*WIDTH  port p occupies slice [p*WIDTH +: WIDTH]. Ports: 0=W, 1=E, 2=S, 3=N, 4=Local.
- in_valid  in  5  per-port valid.
- in_ready  out  5  per-port ready.
- out_data  out  5*WIDTH  same port slicing as in_data.
- out_valid  out  5  per-port valid.
- out_ready  in  5  per-port ready.
- err_uturn  out  5  one-cycle pulse per input port when a U-turn packet is dropped.

## Operation
- Transfer on any channel occurs at a rising edge where valid & ready are both 1. A source holds data stable while valid=1 and ready=0.
- in_ready[p] = !full[p]. It is derived only from registered FIFO state, never from outputs, and is 0 while reset=1.
- Route of a FIFO head uses unsigned compares against MY_X/MY_Y:
  - dX > MY_X → E(1); dX < MY_X → W(0).
  - else dY > MY_Y → N(3); dY < MY_Y → S(2).
  - else Local(4).
- U-turn: a computed route equal to the arrival port (ports 0–3 only). The head is popped without forwarding, and err_uturn[p]=1 for that one cycle. U-turns take no arbitration slot.
- Each head requests exactly one output. Each output arbiter is round-robin: the search starts at last_grant+1 mod 5, and last_grant updates only on a grant.
- The output register for port o loads when (!out_valid[o] | out_ready[o]) and a grant exists. On the same edge the granted FIFO pops. Back-to-back packets sustain 1 packet/cycle per output.
- Packet contents are never modified.

## Timing
- Reset (edge with reset=1): all FIFOs empty; out_valid=0; out_data=0; err_uturn=0; last_grant=4 for every output, so input 0 wins first.
- Latency: a packet accepted at edge t is written to its FIFO and is its head after t. With no contention it loads the output register at edge t+1, so out_valid=1 from t+1. Minimum input-to-output latency is 1 cycle of FIFO residency.
- FIFO full: in_ready=0 even if a pop occurs on the same edge, which costs one bubble. When not full, a push and pop on the same edge leave the count unchanged.
- FIFO empty: no request; pointers wrap mod DEPTH.
- Output stalled (out_valid=1, out_ready=0): out_data is held, no grant is made, and last_grant is unchanged.
- Reset asserted mid-transfer: in-flight packets are discarded. No partial output is emitted after reset deasserts.

## Structure
- Package noc_pkg holds:
  - port index localparams (PORT_W..PORT_L, NPORTS=5);
  - a route function (dest x/y, my x/y → 3-bit port);
  - a round-robin pick function (5-bit request vector, last grant → grant index).
- Sub-module noc_in_fifo (WIDTH, DEPTH) is instantiated 5× via generate. It has push/pop, full/empty, head data, and a registered count.
- Top level contains the route compute, 5 arbiters, the output registers and the U-turn logic.

## Test plan
- MY=(1,1), COORD_W=2. Local sends dest (3,1) → it appears on out E one cycle after acceptance; no other out_valid asserts.
- West sends dest (1,2) → out N. East sends dest (1,0) → out S. A packet to (1,1) on any port → out Local, with data bit-identical including the reserved bit.
- Contention: W and S each present dest (1,1) continuously after reset → Local grants in the order W, S, W, S, with one packet per cycle and out_ready=1 throughout.
- Backpressure: out_ready[E]=0 and West pushes 6 packets to (3,1), DEPTH=4 → 5 are accepted (1 in the output register, 4 in the FIFO) and in_ready[W]=0 before the 6th. Release → all 6 emerge in order.
- U-turn: East delivers dest (3,1) → no out_valid asserts, err_uturn[1] pulses once, and the FIFO empties.
- Reset asserted with 3 packets queued and an output stalled → the next cycle has out_valid=0 and in_ready all 0. After deassert, in_ready=5'b11111 and nothing is emitted.
